// File: rtl/stream_demux_1_4.sv
// -----------------------------------------------------------------------------
// stream_demux_1_4
//
// Purpose:
//   Routes a single valid/ready input stream to one of four output channels.
//   Each channel is a one-entry skid stage: a holding register plus a full
//   flag. Backpressure is evaluated per channel, so a stalled consumer only
//   blocks words addressed to that channel. Each channel also keeps a
//   free-running 8-bit count of delivered words.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - upstream word present
//   in_ready   - word accepted this cycle when in_valid is also high
//   in_sel     - destination channel (0..3) of the current input word
//   in_data    - input word (WIDTH bits)
//   out_valid  - bit k high: channel k holds a word
//   out_ready  - bit k high: channel k consumer takes the word
//   out_data0..out_data3 - holding register contents per channel
//   cnt0..cnt3 - words delivered per channel, wraps 255 -> 0
// -----------------------------------------------------------------------------
module stream_demux_1_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
);

    // Per-channel state: full flag (EMPTY=0 / FULL=1), holding word, counter.
    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [7:0]       cnt_q  [4];
    logic [7:0]       cnt_d  [4];

    // Handshake qualifiers
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       push_s;
    logic [3:0]       pop_s;

    // Input handshake: ready depends only on the addressed channel, so a
    // stalled channel never blocks traffic for the others.
    always_comb begin
        in_ready_s = (~full_q[in_sel]) | out_ready[in_sel];
        accept_s   = in_valid & in_ready_s;
    end

    // Per-channel push/pop decode.
    always_comb begin
        push_s = 4'b0000;
        pop_s  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (accept_s && (in_sel == 2'(k))) begin
                push_s[k] = 1'b1;
            end else begin
                push_s[k] = 1'b0;
            end
            pop_s[k] = full_q[k] & out_ready[k];
        end
    end

    // Next-state for the full flags, holding registers and counters.
    // A push wins over a pop so a simultaneous pop+push keeps the channel
    // full and loads the new word with no bubble.
    always_comb begin
        full_d = full_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
            cnt_d[k]  = cnt_q[k];
            if (push_s[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = in_data;
            end else if (pop_s[k]) begin
                full_d[k] = 1'b0;
            end else begin
                full_d[k] = full_q[k];
            end
            if (pop_s[k]) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // State registers with asynchronous clear of every flag, word and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= {WIDTH{1'b0}};
                cnt_q[k]  <= 8'd0;
            end
        end else begin
            full_q <= full_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // Output mapping: everything except in_ready comes straight from flops.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = full_q;
        out_data0 = data_q[0];
        out_data1 = data_q[1];
        out_data2 = data_q[2];
        out_data3 = data_q[3];
        cnt0      = cnt_q[0];
        cnt1      = cnt_q[1];
        cnt2      = cnt_q[2];
        cnt3      = cnt_q[3];
    end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of the input and of every output channel.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-005 SHALL have port in_ready, output, 1 bit: word accepted this cycle when in_valid is also high.
REQ-006 SHALL have port in_sel, input, 2 bits: destination channel 0..3 of the current input word.
REQ-007 SHALL have port in_data, input, WIDTH bits: input word.
REQ-008 SHALL have port out_valid, output, 4 bits: bit k high means channel k holds a word.
REQ-009 SHALL have port out_ready, input, 4 bits: bit k high means the channel k consumer takes the word.
REQ-010 SHALL have ports out_data0, out_data1, out_data2 and out_data3, output, WIDTH bits each: channel words.
REQ-011 SHALL have ports cnt0, cnt1, cnt2 and cnt3, output, 8 bits each: words delivered per channel.

Function
REQ-012 SHALL keep one holding register plus a full flag per channel k; out_valid[k] SHALL equal full_k, and out_dataK SHALL equal holding register k.
REQ-013 SHALL drive in_ready = !full[in_sel] | out_ready[in_sel]; this is combinational and defined regardless of in_valid.
REQ-014 SHALL accept a word on a cycle where in_valid & in_ready; it is written to channel in_sel, and full is set at the next edge (latency 1 cycle).
REQ-015 SHALL pop channel k on a cycle where full_k & out_ready[k], and clear full_k at the next edge unless the same cycle also accepts into k.
REQ-016 SHALL handle simultaneous pop and accept on the same channel by keeping full_k at 1 and loading the new word; there are no bubbles, so sustained throughput is 1 word/cycle per channel.
REQ-017 SHALL hold out_dataK and out_valid[k] stable while out_valid[k] & !out_ready[k].
REQ-018 SHALL evaluate backpressure per channel only: a stalled channel SHALL NOT block words addressed to other channels.
REQ-019 SHALL never drop, duplicate or reorder words within a channel.
REQ-020 SHALL ignore in_data and in_sel when in_valid is low.
REQ-021 SHALL leave state unchanged when out_ready[k] is high while full_k is 0.
REQ-022 SHALL increment cntK by 1 on each pop of channel k; the counter SHALL wrap from 255 to 0 with no saturation.
REQ-023 SHALL have no internal FSM beyond the four full flags; each flag has two states, EMPTY (0) and FULL (1), with transitions given by REQ-014 to REQ-016.

Reset
REQ-024 SHALL, on rst high, immediately clear all full flags, holding registers and counters to 0, independent of clk.
REQ-025 SHALL drive outputs to out_valid=4'b0000, all out_dataK=0, all cntK=0 and in_ready=1 while rst is high.
REQ-026 SHALL discard any pending words when reset is asserted mid-operation; operation resumes on the first rising edge after rst falls.

Verification
REQ-027 Routing: words 4'hA/sel0, 4'hB/sel1, 4'hC/sel2 and 4'hD/sel3 on consecutive cycles with all out_ready=1 -> each out_valid[k] pulses one cycle after its word, out_dataK carries the matching value, and each cntK=1.
REQ-028 Backpressure: 4'h5 to ch2 with out_ready[2]=0, then 4'h6 to ch2 -> in_ready=0 while sel=2, out_data2 stays 4'h5; after out_ready[2]=1 for one cycle, 4'h6 is accepted and appears the following cycle.
REQ-029 Isolation: ch0 full and stalled while words 1, 2 and 3 go to ch1 with out_ready[1]=1 -> all three are accepted back-to-back, cnt1=3 and cnt0=0.
REQ-030 Same-cycle pop and push: ch3 holds 4'h7 with out_ready[3]=1 while 4'h8 is sent to ch3 -> in_ready=1, out_valid[3] stays 1, and out_data3 reads 4'h7 then 4'h8.
REQ-031 Wrap and reset: 256 pops on ch1 -> cnt1 returns to 0; assert rst asynchronously while ch0 is full -> out_valid=0 and cnt0..cnt3=0 before the next clk edge.
